// File: rtl/ex_stage_core_if.sv
// Execute-stage bus: decoded instruction in, EX/MEM register and hazard flags out.
interface ex_stage_core_if;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic [31:0] i_imm_data;
    logic [31:0] i_pc;
    logic [3:0]  i_alu_ctrl;
    logic [2:0]  i_func3;
    logic [6:0]  i_opcode;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic [4:0]  i_rd_decode;
    logic [4:0]  i_rd_mem;
    logic [31:0] i_mem_result;
    logic        i_is_branch;
    logic [4:0]  i_is_rs1;
    logic [4:0]  i_is_rs2;
    logic [31:0] o_result;
    logic [31:0] o_data_store;
    logic [31:0] o_pc;
    logic [2:0]  o_func3;
    logic [6:0]  o_opcode;
    logic [4:0]  o_rd;
    logic        o_stall;
    logic        o_forward_branch;
    logic        o_decode_forward_rs1;
    logic        o_decode_forward_rs2;

    // Upstream pipeline side: drives the decoded instruction, observes EX/MEM.
    modport master (
        output i_rs1_data, i_rs2_data, i_imm_data, i_pc, i_alu_ctrl, i_func3,
               i_opcode, i_rs1, i_rs2, i_rd_decode, i_rd_mem, i_mem_result,
               i_is_branch, i_is_rs1, i_is_rs2,
        input  o_result, o_data_store, o_pc, o_func3, o_opcode, o_rd,
               o_stall, o_forward_branch, o_decode_forward_rs1, o_decode_forward_rs2
    );

    // Execute-stage side.
    modport slave (
        input  i_rs1_data, i_rs2_data, i_imm_data, i_pc, i_alu_ctrl, i_func3,
               i_opcode, i_rs1, i_rs2, i_rd_decode, i_rd_mem, i_mem_result,
               i_is_branch, i_is_rs1, i_is_rs2,
        output o_result, o_data_store, o_pc, o_func3, o_opcode, o_rd,
               o_stall, o_forward_branch, o_decode_forward_rs1, o_decode_forward_rs2
    );
endinterface

// File: rtl/ex_stage_core.sv
// RV32I execute stage: forwarding muxes, ALU, hazard detection and EX/MEM register.
module ex_stage_core (
    input  logic           clk,
    input  logic           rst,
    ex_stage_core_if.slave bus
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic [31:0] result_q, result_d;
    logic [31:0] store_q, store_d;
    logic [31:0] pc_q;
    logic [2:0]  func3_q;
    logic [6:0]  opcode_q;
    logic [4:0]  rd_q;

    logic        ex_fwd1, ex_fwd2, mem_fwd1, mem_fwd2;
    logic [31:0] fwd1, fwd2, op1, op2, alu_y;
    logic        load_use, branch_stall, stall;
    logic        ex_fwd_ok, uses1, uses2;

    function automatic logic writes_rd(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_JAL) ||
               (op == OP_JALR) || (op == OP_LUI) || (op == OP_AUIPC);
    endfunction

    // Operand forwarding and selection.
    always_comb begin
        ex_fwd_ok = (rd_q != 5'd0) && writes_rd(opcode_q) && (opcode_q != OP_LD);
        ex_fwd1   = ex_fwd_ok && (rd_q == bus.i_rs1);
        ex_fwd2   = ex_fwd_ok && (rd_q == bus.i_rs2);
        mem_fwd1  = (bus.i_rd_mem != 5'd0) && (bus.i_rd_mem == bus.i_rs1);
        mem_fwd2  = (bus.i_rd_mem != 5'd0) && (bus.i_rd_mem == bus.i_rs2);
        fwd1 = ex_fwd1 ? result_q : (mem_fwd1 ? bus.i_mem_result : bus.i_rs1_data);
        fwd2 = ex_fwd2 ? result_q : (mem_fwd2 ? bus.i_mem_result : bus.i_rs2_data);

        op1 = fwd1;
        if ((bus.i_opcode == OP_AUIPC) || (bus.i_opcode == OP_JAL) || (bus.i_opcode == OP_JALR))
            op1 = bus.i_pc;
        else if (bus.i_opcode == OP_LUI)
            op1 = '0;

        op2 = bus.i_imm_data;
        if ((bus.i_opcode == OP_R) || (bus.i_opcode == OP_B))
            op2 = fwd2;
        else if ((bus.i_opcode == OP_JAL) || (bus.i_opcode == OP_JALR))
            op2 = 32'd4;
    end

    // ALU; jumps compute the link address regardless of the decoded ALU code.
    always_comb begin
        alu_y = '0;
        if ((bus.i_opcode == OP_JAL) || (bus.i_opcode == OP_JALR)) begin
            alu_y = op1 + op2;
        end else begin
            case (bus.i_alu_ctrl)
                4'b0000: alu_y = op1 + op2;
                4'b1000: alu_y = op1 - op2;
                4'b0001: alu_y = op1 << op2[4:0];
                4'b0010: alu_y = {31'd0, $signed(op1) < $signed(op2)};
                4'b0011: alu_y = {31'd0, op1 < op2};
                4'b0100: alu_y = op1 ^ op2;
                4'b0101: alu_y = op1 >> op2[4:0];
                4'b1101: alu_y = $unsigned($signed(op1) >>> op2[4:0]);
                4'b0110: alu_y = op1 | op2;
                4'b0111: alu_y = op1 & op2;
                4'b1111: alu_y = op2;
                default: alu_y = '0;
            endcase
        end
    end

    // Load-use and branch-dependency hazards plus decode-stage branch forwarding.
    always_comb begin
        uses1 = (bus.i_opcode != OP_JAL) && (bus.i_opcode != OP_LUI) && (bus.i_opcode != OP_AUIPC);
        uses2 = (bus.i_opcode == OP_R) || (bus.i_opcode == OP_S) || (bus.i_opcode == OP_B);
        load_use = (opcode_q == OP_LD) && (rd_q != 5'd0) &&
                   ((uses1 && (rd_q == bus.i_rs1)) || (uses2 && (rd_q == bus.i_rs2)));
        branch_stall = bus.i_is_branch &&
            (((bus.i_rd_decode != 5'd0) && writes_rd(bus.i_opcode) &&
              ((bus.i_rd_decode == bus.i_is_rs1) || (bus.i_rd_decode == bus.i_is_rs2))) ||
             ((opcode_q == OP_LD) && (rd_q != 5'd0) &&
              ((rd_q == bus.i_is_rs1) || (rd_q == bus.i_is_rs2))));
        stall = load_use || branch_stall;
        bus.o_stall = stall;
        bus.o_decode_forward_rs1 = bus.i_is_branch && !stall && ex_fwd_ok && (rd_q == bus.i_is_rs1);
        bus.o_decode_forward_rs2 = bus.i_is_branch && !stall && ex_fwd_ok && (rd_q == bus.i_is_rs2);
        bus.o_forward_branch = bus.o_decode_forward_rs1 || bus.o_decode_forward_rs2;
        result_d = load_use ? '0 : alu_y;
        store_d  = (bus.i_opcode == OP_S) ? fwd2 : '0;
    end

    // EX/MEM register; a load-use hazard inserts a bubble, branch stalls let EX proceed.
    always_ff @(posedge clk) begin
        if (rst || load_use) begin
            result_q <= '0;
            store_q  <= '0;
            pc_q     <= '0;
            func3_q  <= '0;
            opcode_q <= '0;
            rd_q     <= '0;
        end else begin
            result_q <= result_d;
            store_q  <= store_d;
            pc_q     <= bus.i_pc;
            func3_q  <= bus.i_func3;
            opcode_q <= bus.i_opcode;
            rd_q     <= bus.i_rd_decode;
        end
    end

    assign bus.o_result     = result_q;
    assign bus.o_data_store = store_q;
    assign bus.o_pc         = pc_q;
    assign bus.o_func3      = func3_q;
    assign bus.o_opcode     = opcode_q;
    assign bus.o_rd         = rd_q;
endmodule

// File: tb/tb_ex_stage_core.sv
// Directed and randomized bench for ex_stage_core against a behavioural model.
module tb_ex_stage_core;
    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, S = 7'b0100011,
                           B = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111,
                           LUI = 7'b0110111, AUIPC = 7'b0010111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ex_stage_core_if bus ();
    ex_stage_core dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Model of the EX/MEM register contents.
    logic [31:0] m_res, m_st, m_pc;
    logic [2:0]  m_f3;
    logic [6:0]  m_op;
    logic [4:0]  m_rd;
    // Expected combinational outputs and next register contents.
    logic        e_stall, e_fb, e_f1, e_f2, e_bubble;
    logic [31:0] e_res, e_st;

    function automatic logic wr(input logic [6:0] op);
        return op inside {R, I, LD, JAL, JALR, LUI, AUIPC};
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
        if (m_rd != 0 && m_rd == rs && wr(m_op) && m_op != LD) return m_res;
        if (bus.i_rd_mem != 0 && bus.i_rd_mem == rs) return bus.i_mem_result;
        return rf;
    endfunction

    function automatic logic [31:0] alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        s = b % 32;
        case (c)
            4'd0:  return a + b;
            4'd8:  return a + (~b + 1);
            4'd1:  return a * (32'd1 << s);
            4'd2:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd3:  return (a < b) ? 32'd1 : 32'd0;
            4'd4:  return a ^ b;
            4'd5:  return a / (32'd1 << s);
            4'd13: return (a / (32'd1 << s)) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            4'd6:  return a | b;
            4'd7:  return a & b;
            4'd15: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_eval();
        logic [6:0]  op;
        logic [31:0] f1, f2, a, b;
        logic        lu, bs, fwdok;
        op = bus.i_opcode;
        f1 = operand(bus.i_rs1, bus.i_rs1_data);
        f2 = operand(bus.i_rs2, bus.i_rs2_data);
        a = (op inside {AUIPC, JAL, JALR}) ? bus.i_pc : (op == LUI) ? 32'd0 : f1;
        b = (op inside {R, B}) ? f2 : (op inside {JAL, JALR}) ? 32'd4 : bus.i_imm_data;
        lu = m_op == LD && m_rd != 0 &&
             ((!(op inside {JAL, LUI, AUIPC}) && m_rd == bus.i_rs1) ||
              ((op inside {R, S, B}) && m_rd == bus.i_rs2));
        bs = bus.i_is_branch &&
             ((bus.i_rd_decode != 0 && wr(op) &&
               (bus.i_rd_decode == bus.i_is_rs1 || bus.i_rd_decode == bus.i_is_rs2)) ||
              (m_op == LD && m_rd != 0 && (m_rd == bus.i_is_rs1 || m_rd == bus.i_is_rs2)));
        e_stall  = lu || bs;
        fwdok    = bus.i_is_branch && !e_stall && m_rd != 0 && wr(m_op) && m_op != LD;
        e_f1     = fwdok && m_rd == bus.i_is_rs1;
        e_f2     = fwdok && m_rd == bus.i_is_rs2;
        e_fb     = e_f1 || e_f2;
        e_bubble = lu;
        e_res    = (op inside {JAL, JALR}) ? a + b : alu(bus.i_alu_ctrl, a, b);
        e_st     = (op == S) ? f2 : 32'd0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational flags, advance model, check EX/MEM register.
    task automatic cycle();
        #1;
        model_eval();
        chk("stall", {31'd0, bus.o_stall}, {31'd0, e_stall});
        chk("fwd_branch", {31'd0, bus.o_forward_branch}, {31'd0, e_fb});
        chk("dec_fwd_rs1", {31'd0, bus.o_decode_forward_rs1}, {31'd0, e_f1});
        chk("dec_fwd_rs2", {31'd0, bus.o_decode_forward_rs2}, {31'd0, e_f2});
        @(posedge clk);
        if (rst || e_bubble) begin
            m_res = 0; m_st = 0; m_pc = 0; m_f3 = 0; m_op = 0; m_rd = 0;
        end else begin
            m_res = e_res; m_st = e_st; m_pc = bus.i_pc; m_f3 = bus.i_func3;
            m_op = bus.i_opcode; m_rd = bus.i_rd_decode;
        end
        #1;
        chk("result", bus.o_result, m_res);
        chk("store", bus.o_data_store, m_st);
        chk("pc", bus.o_pc, m_pc);
        chk("func3", {29'd0, bus.o_func3}, {29'd0, m_f3});
        chk("opcode", {25'd0, bus.o_opcode}, {25'd0, m_op});
        chk("rd", {27'd0, bus.o_rd}, {27'd0, m_rd});
    endtask

    task automatic instr(input logic [6:0] op, input logic [3:0] c, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] imm, input logic [31:0] pc);
        bus.i_opcode = op; bus.i_alu_ctrl = c; bus.i_rd_decode = rd;
        bus.i_rs1 = rs1; bus.i_rs2 = rs2; bus.i_rs1_data = d1; bus.i_rs2_data = d2;
        bus.i_imm_data = imm; bus.i_pc = pc; bus.i_func3 = 3'd2;
    endtask

    task automatic quiet();
        bus.i_rd_mem = 0; bus.i_mem_result = 0;
        bus.i_is_branch = 0; bus.i_is_rs1 = 0; bus.i_is_rs2 = 0;
    endtask

    logic [3:0] sweep_c [6];
    logic [31:0] sweep_e [6];
    logic [6:0] ops [9];

    initial begin
        m_res = 0; m_st = 0; m_pc = 0; m_f3 = 0; m_op = 0; m_rd = 0;
        quiet();
        instr(I, 4'd0, 5'd9, 5'd1, 5'd2, 32'h1234, 32'h5678, 32'h9, 32'h40);
        rst = 1'b1;
        cycle(); cycle();
        chk("rst_result", bus.o_result, 32'd0);
        chk("rst_rd", {27'd0, bus.o_rd}, 32'd0);
        chk("rst_stall", {31'd0, bus.o_stall}, 32'd0);
        rst = 1'b0;

        sweep_c = '{4'd0, 4'd8, 4'd2, 4'd3, 4'd13, 4'd5};
        sweep_e = '{32'hFFFF_FFF4, 32'hFFFF_FFEC, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'h0FFF_FFFF};
        for (int k = 0; k < 6; k++) begin
            instr(R, sweep_c[k], 5'd10, 5'd1, 5'd2, 32'hFFFF_FFF0, 32'd4, 32'd0, 32'h10);
            cycle();
            chk("alu_sweep", bus.o_result, sweep_e[k]);
        end

        instr(I, 4'd0, 5'd5, 5'd0, 5'd0, 32'd0, 32'd0, 32'd7, 32'h20); cycle();
        instr(R, 4'd0, 5'd6, 5'd5, 5'd5, 32'd0, 32'd0, 32'd0, 32'h24); cycle();
        chk("ex_fwd", bus.o_result, 32'd14);
        instr(I, 4'd0, 5'd5, 5'd0, 5'd0, 32'd0, 32'd0, 32'd7, 32'h28); cycle();
        bus.i_rd_mem = 5'd5; bus.i_mem_result = 32'd9;
        instr(R, 4'd0, 5'd6, 5'd5, 5'd5, 32'd0, 32'd0, 32'd0, 32'h2C); cycle();
        chk("ex_over_mem", bus.o_result, 32'd14);
        quiet();

        instr(LD, 4'd0, 5'd7, 5'd0, 5'd0, 32'd0, 32'd0, 32'h40, 32'h30); cycle();
        instr(R, 4'd0, 5'd8, 5'd7, 5'd1, 32'd0, 32'd1, 32'd0, 32'h34);
        #1;
        chk("load_use_stall", {31'd0, bus.o_stall}, 32'd1);
        cycle();
        chk("bubble_op", {25'd0, bus.o_opcode}, 32'd0);
        bus.i_rd_mem = 5'd7; bus.i_mem_result = 32'h55;
        cycle();
        chk("after_lu", bus.o_result, 32'h56);
        quiet();

        bus.i_is_branch = 1; bus.i_is_rs1 = 5'd3; bus.i_is_rs2 = 5'd4;
        instr(I, 4'd0, 5'd3, 5'd0, 5'd0, 32'd0, 32'd0, 32'd11, 32'h40);
        #1;
        chk("branch_stall", {31'd0, bus.o_stall}, 32'd1);
        cycle();
        chk("branch_ex_proceeds", {27'd0, bus.o_rd}, 32'd3);
        instr(7'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h44);
        #1;
        chk("branch_fwd", {30'd0, bus.o_forward_branch, bus.o_decode_forward_rs1}, 32'd3);
        cycle();
        quiet();

        instr(I, 4'd0, 5'd9, 5'd0, 5'd0, 32'd0, 32'd0, 32'hABCD, 32'h50); cycle();
        instr(S, 4'd0, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd8, 32'h54); cycle();
        chk("store_fwd", bus.o_data_store, 32'hABCD);
        instr(AUIPC, 4'd0, 5'd11, 5'd0, 5'd0, 32'd0, 32'd0, 32'h1000, 32'h100); cycle();
        chk("auipc", bus.o_result, 32'h1100);
        instr(JAL, 4'd4, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 32'h80, 32'h200); cycle();
        chk("jal", bus.o_result, 32'h204);

        rst = 1'b1;
        instr(R, 4'd6, 5'd12, 5'd1, 5'd2, 32'hF0, 32'h0F, 32'd0, 32'h300); cycle();
        chk("mid_rst", bus.o_result, 32'd0);
        rst = 1'b0;

        ops = '{R, I, LD, S, B, JAL, JALR, LUI, AUIPC};
        for (int n = 0; n < 400; n++) begin
            instr(ops[$urandom_range(8)], 4'($urandom), 5'($urandom_range(3)), 5'($urandom_range(3)),
                  5'($urandom_range(3)), $urandom, ($urandom_range(1) == 1) ? $urandom : 32'($urandom_range(40)),
                  $urandom, $urandom);
            bus.i_func3 = 3'($urandom);
            bus.i_rd_mem = 5'($urandom_range(3)); bus.i_mem_result = $urandom;
            bus.i_is_branch = 1'($urandom); bus.i_is_rs1 = 5'($urandom_range(3));
            bus.i_is_rs2 = 5'($urandom_range(3));
            rst = ($urandom_range(60) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
